// File: rtl/laptop_img_rx.sv
// Receives a row-major byte stream from the host into a packed frame buffer,
// pulses laptop_img_rdy once a frame is complete and holds it until the detector releases it.
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 4
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 3
`endif

module laptop_img_rx #(
   parameter int LAPTOP_WIDTH  = `LAPTOP_WIDTH,
   parameter int LAPTOP_HEIGHT = `LAPTOP_HEIGHT
) (
   input  logic                                           clock,
   input  logic                                           reset,
   input  logic [7:0]                                     byte_in,
   input  logic                                           byte_valid,
   input  logic                                           byte_sof,
   output logic                                           byte_ready,
   input  logic                                           detector_done,
   output logic [LAPTOP_HEIGHT-1:0][LAPTOP_WIDTH-1:0][7:0] laptop_img,
   output logic                                           laptop_img_rdy,
   output logic [31:0]                                    row_index,
   output logic [31:0]                                    col_index,
   output logic [7:0]                                     frame_count
);

   localparam int RW = (LAPTOP_HEIGHT > 1) ? $clog2(LAPTOP_HEIGHT) : 1;
   localparam int CW = (LAPTOP_WIDTH > 1) ? $clog2(LAPTOP_WIDTH) : 1;
   localparam logic [31:0] LAST_ROW = 32'(LAPTOP_HEIGHT - 1);
   localparam logic [31:0] LAST_COL = 32'(LAPTOP_WIDTH - 1);
   // After a start-of-frame pixel the next position is (0,1), or (1,0) for single-column frames.
   localparam logic [31:0] SOF_ROW  = (LAPTOP_WIDTH == 1) ? 32'd1 : 32'd0;
   localparam logic [31:0] SOF_COL  = (LAPTOP_WIDTH == 1) ? 32'd0 : 32'd1;

   typedef enum logic [1:0] {IDLE, LOAD, PULSE, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] row_q, row_d;
   logic [31:0] col_q, col_d;
   logic [7:0]  frame_q, frame_d;
   logic        rdy_q, rdy_d;
   logic [LAPTOP_HEIGHT-1:0][LAPTOP_WIDTH-1:0][7:0] img_q, img_d;
   logic        accept;

   assign byte_ready     = !reset && ((state_q == IDLE) || (state_q == LOAD));
   assign accept         = byte_valid && byte_ready;
   assign laptop_img_rdy = rdy_q && !reset;
   assign laptop_img     = img_q;
   assign row_index      = row_q;
   assign col_index      = col_q;
   assign frame_count    = frame_q;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      frame_d = frame_q;
      img_d   = img_q;
      rdy_d   = 1'b0;
      case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               state_d = LOAD;
               if (byte_sof) begin
                  img_d[0][0] = byte_in;
                  row_d       = SOF_ROW;
                  col_d       = SOF_COL;
               end else begin
                  img_d[row_q[RW-1:0]][col_q[CW-1:0]] = byte_in;
                  if (col_q == LAST_COL) begin
                     col_d = 32'd0;
                     if (row_q == LAST_ROW) begin
                        row_d   = 32'd0;
                        state_d = PULSE;
                        rdy_d   = 1'b1;
                        frame_d = frame_q + 8'd1;
                     end else begin
                        row_d = row_q + 32'd1;
                     end
                  end else begin
                     col_d = col_q + 32'd1;
                  end
               end
            end
         end
         PULSE: state_d = HOLD;
         HOLD: begin
            if (detector_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         row_q   <= 32'd0;
         col_q   <= 32'd0;
         frame_q <= 8'd0;
         rdy_q   <= 1'b0;
         img_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         frame_q <= frame_d;
         rdy_q   <= rdy_d;
         img_q   <= img_d;
      end
   end

endmodule

// File: tb/tb_laptop_img_rx.sv
// Directed bench for laptop_img_rx with a 4x3 frame: streaming, hold, sof restart,
// reset mid-frame and frame_count wrap over 256 frames.
module tb_laptop_img_rx;

   localparam int W = 4;
   localparam int H = 3;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        byte_in = 8'd0;
   logic              byte_valid = 1'b0;
   logic              byte_sof = 1'b0;
   logic              byte_ready;
   logic              detector_done = 1'b0;
   logic [H-1:0][W-1:0][7:0] laptop_img;
   logic              laptop_img_rdy;
   logic [31:0]       row_index;
   logic [31:0]       col_index;
   logic [7:0]        frame_count;

   int checks = 0;
   int errors = 0;
   logic [7:0] expImg [H][W];

   laptop_img_rx #(.LAPTOP_WIDTH(W), .LAPTOP_HEIGHT(H)) dut (
      .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_sof(byte_sof), .byte_ready(byte_ready), .detector_done(detector_done),
      .laptop_img(laptop_img), .laptop_img_rdy(laptop_img_rdy), .row_index(row_index),
      .col_index(col_index), .frame_count(frame_count)
   );

   always #5 clock = ~clock;

   // Watchdog so the run always terminates even if the bench logic stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [95:0] packImg();
      logic [95:0] v = '0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            v[(r*W+c)*8 +: 8] = expImg[r][c];
      return v;
   endfunction

   // Drives one cycle of inputs and returns 1ns after the rising edge.
   task automatic applyStimulus(input logic [7:0] b, input logic sof, input logic valid,
                                input logic done);
      byte_in       = b;
      byte_sof      = sof;
      byte_valid    = valid;
      detector_done = done;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset with a valid byte present: nothing may be accepted.
      byte_valid = 1'b1;
      byte_in    = 8'h5A;
      applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1);
      applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1);
      checkOutput("rst_ready", 96'(byte_ready), 96'd0);
      checkOutput("rst_rdy", 96'(laptop_img_rdy), 96'd0);
      checkOutput("rst_row", 96'(row_index), 96'd0);
      checkOutput("rst_col", 96'(col_index), 96'd0);
      checkOutput("rst_frame", 96'(frame_count), 96'd0);
      checkOutput("rst_img", laptop_img, 96'd0);

      reset = 1'b0;
      byte_valid = 1'b0;
      detector_done = 1'b0;
      #1;
      checkOutput("post_rst_ready", 96'(byte_ready), 96'd1);

      // Frame 1: bytes 0..11 back to back.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(8'(i), 1'b0, 1'b1, 1'b0);
         expImg[i/W][i%W] = 8'(i);
         if (i == 0) begin
            checkOutput("f1_col_after0", 96'(col_index), 96'd1);
            checkOutput("f1_rdy_after0", 96'(laptop_img_rdy), 96'd0);
         end
         if (i == 3) begin
            checkOutput("f1_row_wrap", 96'(row_index), 96'd1);
            checkOutput("f1_col_wrap", 96'(col_index), 96'd0);
         end
      end
      checkOutput("f1_rdy", 96'(laptop_img_rdy), 96'd1);
      checkOutput("f1_frame", 96'(frame_count), 96'd1);
      checkOutput("f1_ready", 96'(byte_ready), 96'd0);
      checkOutput("f1_img", laptop_img, packImg());
      checkOutput("f1_row", 96'(row_index), 96'd0);
      checkOutput("f1_col", 96'(col_index), 96'd0);

      // detector_done during PULSE must be ignored; we should land in HOLD.
      applyStimulus(8'hEE, 1'b0, 1'b1, 1'b1);
      checkOutput("hold_rdy_low", 96'(laptop_img_rdy), 96'd0);
      checkOutput("hold_ready", 96'(byte_ready), 96'd0);
      for (int i = 0; i < 5; i++)
         applyStimulus(8'hC0 + 8'(i), 1'b0, 1'b1, 1'b0);
      checkOutput("hold_img", laptop_img, packImg());
      checkOutput("hold_row", 96'(row_index), 96'd0);
      checkOutput("hold_col", 96'(col_index), 96'd0);
      checkOutput("hold_frame", 96'(frame_count), 96'd1);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
      checkOutput("release_ready", 96'(byte_ready), 96'd1);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
      checkOutput("idle_done_ready", 96'(byte_ready), 96'd1);
      checkOutput("idle_done_col", 96'(col_index), 96'd0);

      // Frame 2: six bytes, then a start-of-frame restart, then eleven more.
      for (int i = 0; i < 6; i++)
         applyStimulus(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
      applyStimulus(8'hAA, 1'b1, 1'b1, 1'b0);
      checkOutput("sof_pix", 96'(laptop_img[0][0]), 96'hAA);
      checkOutput("sof_keep", 96'(laptop_img[1][1]), 96'h15);
      checkOutput("sof_row", 96'(row_index), 96'd0);
      checkOutput("sof_col", 96'(col_index), 96'd1);
      expImg[0][0] = 8'hAA;
      for (int i = 0; i < 11; i++) begin
         applyStimulus(8'h20 + 8'(i), 1'b0, 1'b1, 1'b0);
         expImg[(i+1)/W][(i+1)%W] = 8'h20 + 8'(i);
         if (i == 9) checkOutput("f2_rdy_early", 96'(laptop_img_rdy), 96'd0);
      end
      checkOutput("f2_rdy", 96'(laptop_img_rdy), 96'd1);
      checkOutput("f2_frame", 96'(frame_count), 96'd2);
      checkOutput("f2_img", laptop_img, packImg());
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

      // Start-of-frame on the last pixel position restarts instead of completing.
      for (int i = 0; i < 11; i++)
         applyStimulus(8'h30 + 8'(i), 1'b0, 1'b1, 1'b0);
      applyStimulus(8'hBB, 1'b1, 1'b1, 1'b0);
      checkOutput("sof_last_rdy", 96'(laptop_img_rdy), 96'd0);
      checkOutput("sof_last_row", 96'(row_index), 96'd0);
      checkOutput("sof_last_col", 96'(col_index), 96'd1);
      checkOutput("sof_last_pix", 96'(laptop_img[0][0]), 96'hBB);
      checkOutput("sof_last_frame", 96'(frame_count), 96'd2);

      // Reset after seven bytes of this frame, with valid and done also asserted.
      for (int i = 0; i < 6; i++)
         applyStimulus(8'h40 + 8'(i), 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      byte_valid = 1'b1;
      detector_done = 1'b1;
      byte_in = 8'h77;
      #1;
      checkOutput("mid_rst_ready", 96'(byte_ready), 96'd0);
      checkOutput("mid_rst_rdy", 96'(laptop_img_rdy), 96'd0);
      applyStimulus(8'h77, 1'b0, 1'b1, 1'b1);
      checkOutput("mid_rst_img", laptop_img, 96'd0);
      checkOutput("mid_rst_row", 96'(row_index), 96'd0);
      checkOutput("mid_rst_col", 96'(col_index), 96'd0);
      checkOutput("mid_rst_frame", 96'(frame_count), 96'd0);
      checkOutput("mid_rst_rdy2", 96'(laptop_img_rdy), 96'd0);
      reset = 1'b0;
      byte_valid = 1'b0;
      detector_done = 1'b0;
      #1;
      checkOutput("mid_rst_release_ready", 96'(byte_ready), 96'd1);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(8'h50 + 8'(i), 1'b0, 1'b1, 1'b0);
         expImg[i/W][i%W] = 8'h50 + 8'(i);
      end
      checkOutput("fresh_rdy", 96'(laptop_img_rdy), 96'd1);
      checkOutput("fresh_frame", 96'(frame_count), 96'd1);
      checkOutput("fresh_img", laptop_img, packImg());
      applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

      // 255 further frames with idle gaps; frame_count wraps to zero on the last.
      for (int f = 1; f < 256; f++) begin
         for (int i = 0; i < 12; i++) begin
            if (((f + i) % 3) == 0)
               applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
            applyStimulus(8'(f + i*3), 1'b0, 1'b1, 1'b0);
            expImg[i/W][i%W] = 8'(f + i*3);
         end
         checkOutput("wrap_rdy", 96'(laptop_img_rdy), 96'd1);
         checkOutput("wrap_frame", 96'(frame_count), 96'((f + 1) % 256));
         checkOutput("wrap_img", laptop_img, packImg());
         applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
         applyStimulus(8'hFE, 1'b0, 1'b1, 1'b1);
         checkOutput("wrap_held_img", laptop_img, packImg());
      end
      checkOutput("wrap_final_frame", 96'(frame_count), 96'd0);
      checkOutput("wrap_final_ready", 96'(byte_ready), 96'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
